bin_to_dec: RTL and testbench
=============================

BIN_TO_DEC -- requirements
Module: bin_to_dec

Interface
REQ-001 Parameter BIT_DEPTH, default 32, width of the unsigned binary input.
REQ-002 Parameter DIGITS, default 10, number of decimal digit slots; SHALL satisfy 10^DIGITS > 2^BIT_DEPTH-1.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  value is presented.
REQ-007 in_ready  output  1  block can accept a value.
REQ-008 value  input  BIT_DEPTH  unsigned binary number to convert.
REQ-009 out_valid  output  1  out_digit/out_last are valid.
REQ-010 out_ready  input  1  consumer accepts the current digit.
REQ-011 out_digit  output  4  BCD digit 0..9.
REQ-012 out_last  output  1  marks the least-significant (final) digit of a number.

Function
REQ-013 FSM states: IDLE, CONVERT, EMIT; encoding from the shared package.
REQ-014 IDLE: in_ready=1, out_valid=0; in_valid&&in_ready at an edge latches value into work register, clears digit count, goes to CONVERT.
REQ-015 CONVERT: each cycle feeds work register as dividend and constant 10 (BIT_DEPTH wide) as divisor to the combinational divider; at the edge stores remainder[3:0] into digit buffer slot count, loads quotient into work register, increments count.
REQ-016 CONVERT exits to EMIT after the edge where quotient==0 or count reaches DIGITS; an n-digit value spends exactly n cycles in CONVERT; value 0 yields exactly one digit '0'.
REQ-017 out_valid asserts in the first cycle of EMIT (i.e. n+1 cycles after acceptance); in_ready=0 in CONVERT and EMIT.
REQ-018 EMIT: digits presented most-significant first from the buffer; a digit advances only on an edge with out_valid&&out_ready.
REQ-019 out_digit, out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 out_last=1 only with slot 0; its handshake returns FSM to IDLE, out_valid=0 the next cycle; no new value accepted in the same cycle (one idle bubble minimum).
REQ-021 in_valid while not in IDLE is ignored; value changes outside IDLE have no effect.
REQ-022 Maximum value 2^BIT_DEPTH-1 SHALL convert without truncation; buffer is DIGITS x 4 bits.

Reset
REQ-023 rst_n low at any time (including mid-CONVERT/EMIT) immediately forces IDLE, out_valid=0, out_digit=0, out_last=0, count=0, work register 0, buffer cleared; in_ready=1 during and after reset.
REQ-024 In-flight number is discarded; first handshake after rst_n rises behaves as from power-up.

Configuration
REQ-025 Macro BIN_TO_DEC_LEADING_ZEROS_EN: when defined, CONVERT always runs DIGITS cycles and EMIT outputs all DIGITS digits including leading zeros.
REQ-026 Without BIN_TO_DEC_LEADING_ZEROS_EN, leading zeros are suppressed per REQ-016 (minimum one digit).

Structure
REQ-027 Shared package bin_to_dec_pkg holds FSM state encoding, RADIX=10 constant, digit width 4.
REQ-028 One sub-module instance: division_tickless with BIT_DEPTH passed through; no other divider logic in this block.

Verification
REQ-029 value=1234, out_ready=1 -> in_ready low 4+cycles, digits 1,2,3,4 on consecutive cycles, out_last only with 4.
REQ-030 value=0 -> single digit 0 with out_last=1, out_valid asserted 2 cycles after acceptance.
REQ-031 value=4294967295 (BIT_DEPTH=32) -> 4,2,9,4,9,6,7,2,9,5, out_last on final 5.
REQ-032 value=907, out_ready toggled 0/1 each cycle -> digit held stable while stalled, sequence 9,0,7 unchanged.
REQ-033 value=56789, rst_n pulsed low after second digit emitted -> out_valid 0 immediately, in_ready 1; next value=42 yields 4,2 only.
REQ-034 With BIN_TO_DEC_LEADING_ZEROS_EN, value=1234 -> 0,0,0,0,0,0,1,2,3,4, out_last on 4.

Source files
------------

// File: rtl/bin_to_dec_pkg.sv
// -----------------------------------------------------------------------------
// bin_to_dec_pkg
// Shared definitions for the binary-to-decimal converter:
//   - state_e   : FSM state encoding (IDLE / CONVERT / EMIT)
//   - RADIX     : number base used by the digit extraction
//   - DIGIT_W   : width of one BCD digit
// -----------------------------------------------------------------------------
package bin_to_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_EMIT    = 2'd2
  } state_e;

  localparam int RADIX   = 10;
  localparam int DIGIT_W = 4;

endpackage : bin_to_dec_pkg

// File: rtl/division_tickless.sv
// -----------------------------------------------------------------------------
// division_tickless
// Purely combinational unsigned restoring divider (no clock, result in the
// same cycle the operands are presented).
// Ports:
//   dividend  [BIT_DEPTH-1:0]  numerator
//   divisor   [BIT_DEPTH-1:0]  denominator (0 yields all-ones quotient,
//                              remainder = dividend)
//   quotient  [BIT_DEPTH-1:0]  dividend / divisor
//   remainder [BIT_DEPTH-1:0]  dividend % divisor
// -----------------------------------------------------------------------------
module division_tickless #(
  parameter int BIT_DEPTH = 32
) (
  input  logic [BIT_DEPTH-1:0] dividend,
  input  logic [BIT_DEPTH-1:0] divisor,
  output logic [BIT_DEPTH-1:0] quotient,
  output logic [BIT_DEPTH-1:0] remainder
);

  // One extra bit so the shifted partial remainder never overflows before
  // the compare against a large divisor.
  logic [BIT_DEPTH:0]   part_s;
  logic [BIT_DEPTH-1:0] quot_s;

  // Bit-serial long division unrolled across all dividend bits, MSB first.
  always_comb begin
    part_s = {(BIT_DEPTH+1){1'b0}};
    quot_s = {BIT_DEPTH{1'b0}};
    for (int i = BIT_DEPTH - 1; i >= 0; i--) begin
      part_s = {part_s[BIT_DEPTH-1:0], dividend[i]};
      if (part_s >= {1'b0, divisor}) begin
        part_s    = part_s - {1'b0, divisor};
        quot_s[i] = 1'b1;
      end else begin
        quot_s[i] = 1'b0;
      end
    end
  end

  assign quotient  = quot_s;
  assign remainder = part_s[BIT_DEPTH-1:0];

endmodule : division_tickless

// File: rtl/bin_to_dec.sv
// -----------------------------------------------------------------------------
// bin_to_dec
// Converts an unsigned binary number into a stream of BCD digits, most
// significant first. One digit is extracted per cycle (value % 10) into a
// digit buffer, then the buffer is replayed in reverse over a valid/ready
// output handshake.
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   value is presented
//   in_ready   block can accept a value (IDLE only)
//   value      [BIT_DEPTH-1:0] number to convert
//   out_valid  out_digit/out_last are valid
//   out_ready  consumer accepts the current digit
//   out_digit  [3:0] BCD digit
//   out_last   final (least-significant) digit of the number
// Configuration macro:
//   BIN_TO_DEC_LEADING_ZEROS_EN - when defined, always emit DIGITS digits
//   including leading zeros; otherwise leading zeros are suppressed (at least
//   one digit is always emitted).
// -----------------------------------------------------------------------------
import bin_to_dec_pkg::*;

module bin_to_dec #(
  parameter int BIT_DEPTH = 32,
  parameter int DIGITS    = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_DEPTH-1:0] value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_digit,
  output logic                 out_last
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e               state_r, state_s;
  // In CONVERT: slot being written. In EMIT: slot currently presented.
  logic [CNT_W-1:0]     count_r, count_s;
  logic [BIT_DEPTH-1:0] work_r, work_s;
  logic [DIGIT_W-1:0]   digit_buf_r [DIGITS];

  logic                 in_ready_r, in_ready_s;
  logic                 out_valid_r, out_valid_s;
  logic [DIGIT_W-1:0]   out_digit_r, out_digit_s;
  logic                 out_last_r, out_last_s;

  logic [BIT_DEPTH-1:0] quot_s;
  logic [BIT_DEPTH-1:0] rem_s;
  logic                 conv_done_s;
  logic                 unused_rem_s;

  division_tickless #(
    .BIT_DEPTH (BIT_DEPTH)
  ) u_div (
    .dividend  (work_r),
    .divisor   (BIT_DEPTH'(RADIX)),
    .quotient  (quot_s),
    .remainder (rem_s)
  );

  // Remainder is always < RADIX, so only the low digit bits carry data.
  assign unused_rem_s = ^rem_s[BIT_DEPTH-1:DIGIT_W];

  // Decide when digit extraction stops.
  always_comb begin
`ifdef BIN_TO_DEC_LEADING_ZEROS_EN
    conv_done_s = (count_r == LAST_SLOT);
`else
    conv_done_s = (quot_s == {BIT_DEPTH{1'b0}}) || (count_r == LAST_SLOT);
`endif
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so they can be driven straight from flops.
  always_comb begin
    state_s     = state_r;
    count_s     = count_r;
    work_s      = work_r;
    in_ready_s  = in_ready_r;
    out_valid_s = out_valid_r;
    out_digit_s = out_digit_r;
    out_last_s  = out_last_r;

    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s    = ST_CONVERT;
          work_s     = value;
          count_s    = CNT_ZERO;
          in_ready_s = 1'b0;
        end else begin
          state_s    = ST_IDLE;
        end
      end

      ST_CONVERT: begin
        work_s = quot_s;
        if (conv_done_s) begin
          // Slot count_r is the most significant digit; present it directly
          // from the divider since the buffer write lands on this same edge.
          state_s     = ST_EMIT;
          out_valid_s = 1'b1;
          out_digit_s = rem_s[DIGIT_W-1:0];
          out_last_s  = (count_r == CNT_ZERO);
        end else begin
          count_s     = count_r + CNT_ONE;
        end
      end

      ST_EMIT: begin
        if (out_ready) begin
          if (count_r == CNT_ZERO) begin
            state_s     = ST_IDLE;
            in_ready_s  = 1'b1;
            out_valid_s = 1'b0;
            out_digit_s = 4'd0;
            out_last_s  = 1'b0;
          end else begin
            count_s     = count_r - CNT_ONE;
            out_digit_s = digit_buf_r[count_r - CNT_ONE];
            out_last_s  = (count_r == CNT_ONE);
          end
        end else begin
          state_s = ST_EMIT;
        end
      end

      default: begin
        state_s     = ST_IDLE;
        count_s     = CNT_ZERO;
        work_s      = {BIT_DEPTH{1'b0}};
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
        out_digit_s = 4'd0;
        out_last_s  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      count_r     <= CNT_ZERO;
      work_r      <= {BIT_DEPTH{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_digit_r <= 4'd0;
      out_last_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      count_r     <= count_s;
      work_r      <= work_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      out_digit_r <= out_digit_s;
      out_last_r  <= out_last_s;
    end
  end

  // Digit buffer: one remainder captured per CONVERT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) begin
        digit_buf_r[i] <= 4'd0;
      end
    end else if (state_r == ST_CONVERT) begin
      digit_buf_r[count_r] <= rem_s[DIGIT_W-1:0];
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_digit = out_digit_r;
  assign out_last  = out_last_r;

endmodule : bin_to_dec

// File: tb/tb_bin_to_dec.sv
// -----------------------------------------------------------------------------
// tb_bin_to_dec
// Directed bench for bin_to_dec (BIT_DEPTH=32, DIGITS=10). Expected digit
// sequences are written as BCD hex constants; latency is checked as n+1
// cycles from acceptance to the first valid digit.
// Honours BIN_TO_DEC_LEADING_ZEROS_EN (expects all 10 digits when defined).
// -----------------------------------------------------------------------------
module tb_bin_to_dec;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] value;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_digit;
  logic        out_last;

  int checks;
  int errors;

  bin_to_dec #(
    .BIT_DEPTH (32),
    .DIGITS    (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .value     (value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_digit (out_digit),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Digit count actually emitted for a number with n significant digits.
  function automatic int emitted(input int n);
`ifdef BIN_TO_DEC_LEADING_ZEROS_EN
    emitted = 10;
`else
    emitted = n;
`endif
  endfunction

  // Present v for one cycle; returns at the negedge after the accepting edge.
  task automatic accept(input logic [31:0] v);
    @(negedge clk);
    check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    value    = v;
    @(negedge clk);
  endtask

  // Count cycles until out_valid while poking in_valid/value (must be ignored).
  task automatic wait_valid(input int n);
    int lat;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      check("in_ready_busy", {63'd0, in_ready}, 64'd0);
      in_valid = 1'b1;
      value    = $urandom;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 64'(lat), 64'(n + 1));
    check("in_ready_emit", {63'd0, in_ready}, 64'd0);
  endtask

  // Consume 'take' digits of an n-digit BCD sequence (MSB first).
  task automatic collect(input logic [39:0] bcd, input int n, input int take, input bit stall);
    logic [3:0] exp_d;
    for (int i = n - 1; i >= n - take; i--) begin
      exp_d = bcd[i*4 +: 4];
      if (stall) begin
        out_ready = 1'b0;
        @(negedge clk);
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_digit", {60'd0, out_digit}, {60'd0, exp_d});
        check("stall_last", {63'd0, out_last}, {63'd0, (i == 0)});
        out_ready = 1'b1;
      end
      check("digit_valid", {63'd0, out_valid}, 64'd1);
      check("digit", {60'd0, out_digit}, {60'd0, exp_d});
      check("last", {63'd0, out_last}, {63'd0, (i == 0)});
      @(negedge clk);
    end
    if (take == n) begin
      check("idle_valid", {63'd0, out_valid}, 64'd0);
      check("idle_ready", {63'd0, in_ready}, 64'd1);
    end
  endtask

  task automatic run_number(input logic [31:0] v, input logic [39:0] bcd, input int n, input bit stall);
    int ne;
    ne = emitted(n);
    accept(v);
    wait_valid(ne);
    collect(bcd, ne, ne, stall);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    value     = 32'd0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_digit", {60'd0, out_digit}, 64'd0);
    check("rst_out_last", {63'd0, out_last}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_number(32'd1234, 40'h1234, 4, 1'b0);
    run_number(32'd0, 40'h0, 1, 1'b0);
    run_number(32'd4294967295, 40'h4294967295, 10, 1'b0);
    run_number(32'd907, 40'h907, 3, 1'b1);

    // Reset in the middle of EMIT, after two digits were consumed.
    accept(32'd56789);
    wait_valid(emitted(5));
    collect(40'h56789, emitted(5), 2, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_digit", {60'd0, out_digit}, 64'd0);
    check("midrst_out_last", {63'd0, out_last}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_number(32'd42, 40'h42, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule : tb_bin_to_dec
